seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Clocked, parametrised successor to the SM83 combinational ALU/flag block.
- Generalises datapath width W and adds a double-width add (ADDW, the ADD HL,rr class) executed as two W-bit passes.
- Owns the Z/N/H/C flag register, with per-op write masks and a flag-load path (POP AF class).
- Sits between the decoder/register file and the flag consumers, using a valid/ready request handshake.

Parameters:
- W, 8, pass width in bits. Must be even and >= 4.
- IW, $clog2(W), width of the bit-index field.

Ports:
- CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  5  operation code (see package).
- req_idx  in  IW  bit index for BIT/SET/RES.
- req_a  in  2W  operand A; narrow ops use [W-1:0].
- req_b  in  2W  operand B; narrow ops use [W-1:0].
- res  out  2W  result; narrow ops zero-extend.
- res_valid  out  1  one-cycle pulse; res, res_we and op_illegal are valid with it.
- res_we  out  1  result is to be written back (0 for CP, BIT, SCF, CCF).
- op_illegal  out  1  undefined opcode, or DAA with W!=8.
- flags_q  out  4  {Z,N,H,C} at bits 3..0.
- flags_load  in  1  load flags_in into the flag register.
- flags_in  in  4  flag load value.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high, on RESET.
- Reset values: state IDLE, flags_q 0, res 0, res_valid 0, res_we 0, op_illegal 0. RESET during WIDE_HI discards the in-flight op; no res_valid is produced for it.
- States:
  - IDLE: req_ready = ~flags_load.
  - WIDE_HI: req_ready = 0.
- Narrow op accepted at edge k: res, res_we and flags update at edge k. res_valid is high in cycle k+1 (latency 1), and the state stays IDLE. Back-to-back issue runs at 1 op/cycle. The next op sees the updated flags (ADD then ADC forwards C with no bubble).
- ADDW accepted at edge k:
  - Low pass a[W-1:0]+b[W-1:0] is latched with its carry; state goes to WIDE_HI.
  - Edge k+1: high pass a[2W-1:W]+b[2W-1:W]+carry produces res, and flags update.
  - res_valid is high in cycle k+2; state returns to IDLE.
- flags_load in IDLE: the flag register takes flags_in at the next edge. req_ready is 0 that cycle, so load and request never coincide. flags_load during WIDE_HI is ignored.
- Adder rules: H = carry or borrow out of bit W/2-1 of the pass; C = carry or borrow out of bit W-1. SBC/ADC use current C. SUB/SBC/CP set N=1.
- Flag rules per op (Z is res==0 over W bits unless stated; "-" means unchanged):
  - ADD, ADC: Z, N0, H, C.
  - SUB, SBC, CP: Z, N1, H, C. CP has res_we=0.
  - AND: Z, N0, H1, C0.
  - OR, XOR: Z, N0, H0, C0.
  - RLC, RRC, RL, RR, SLA, SRA, SRL: Z, N0, H0, C = bit shifted out. RL/RR shift C in; SRA keeps MSB.
  - SWAP (exchange W/2 halves): Z, N0, H0, C0.
  - BIT: Z = ~a[idx], N0, H1, C-. res_we=0.
  - SET, RES: no flag change.
  - DAA (W=8 only): standard SM83 correction. Z, N-, H0, C set if correction >= 0x60, else kept.
  - CPL: res = ~a, N1, H1.
  - SCF: N0, H0, C1.
  - CCF: N0, H0, C = ~C.
  - ADDW: Z-, N0, H and C from the high pass.
- Illegal op: res = a, no flag change, res_we=0, op_illegal=1 with res_valid.

Decomposition:
- seq_alu_pkg holds:
  - the op enum (24 codes, 5 bits);
  - flag bit positions FLAG_Z/N/H/C;
  - a function returning the 4-bit flag write mask per op;
  - the DAA correction constants.
- One sub-module, alu_pass: a combinational W-bit pass taking a, b, cin, op and idx, producing res, cout and hout. It is shared by the narrow path and both ADDW passes.

Test Plan:
- ADD a=0x3A b=0xC6 (flags 0) -> res 0x00, flags_q 4'b1011, res_valid in the cycle after accept, res_we 1.
- ADD 0xFF+0x01, then ADC 0x00+0x00 on the next cycle -> first res 0x00 C1; second res 0x01 flags 4'b0000; no stall.
- ADDW a=0x0FFF b=0x0001 with Z=1 -> req_ready low one cycle, res 0x1000, res_valid two cycles after accept, flags_q 4'b1010.
- ADD 0x45+0x38 then DAA -> res 0x7D, then 0x83 with flags 4'b0000. DAA with W=16 -> op_illegal 1, res = a, flags unchanged.
- BIT idx=7 a=0x7F with C=1 -> flags 4'b1011, res_we 0. SET idx=0 a=0x00 -> res 0x01, flags unchanged. RLC a=0x80 -> res 0x01, C1.
- RESET asserted in WIDE_HI -> next cycle flags_q 0, res_valid 0, req_ready 1, no result pulse. flags_load=1 with flags_in=4'hA and req_valid=1 in IDLE -> req_ready 0, flags_q 4'hA next cycle, request accepted the cycle after.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag positions,
// per-op flag write masks and DAA correction constants.
package seq_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP, OP_AND, OP_OR, OP_XOR,
    OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL, OP_SWAP,
    OP_BIT, OP_SET, OP_RES, OP_DAA, OP_CPL, OP_SCF, OP_CCF, OP_ADDW
  } op_e;

  localparam logic [4:0] OP_LAST = 5'd23;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

  localparam logic [7:0] DAA_LO_CORR  = 8'h06;
  localparam logic [7:0] DAA_HI_CORR  = 8'h60;
  localparam logic [7:0] DAA_HI_LIMIT = 8'h99;
  localparam logic [3:0] DAA_LO_LIMIT = 4'h9;

  // Which of {Z,N,H,C} an op is allowed to write.
  function automatic logic [3:0] flag_mask(input op_e op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP,
      OP_AND, OP_OR, OP_XOR,
      OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL,
      OP_SWAP:                          flag_mask = 4'b1111;
      OP_BIT:                           flag_mask = 4'b1110;
      OP_DAA:                           flag_mask = 4'b1011;
      OP_CPL:                           flag_mask = 4'b0110;
      OP_SCF, OP_CCF, OP_ADDW:          flag_mask = 4'b0111;
      default:                          flag_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/seq_alu_alu_pass.sv
// Combinational W-bit ALU pass shared by narrow ops and both ADDW halves.
module alu_pass
  import seq_alu_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = $clog2(W)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          cin,
  input  op_e           op,
  input  logic [IW-1:0] idx,
  output logic [W-1:0]  res,
  output logic          cout,
  output logic          hout
);

  localparam int unsigned HW = W / 2;

  logic [W:0]  add_full, sub_full;
  logic [HW:0] add_half, sub_half;
  logic [W-1:0] bit_sel;

  // Bit HW of the half sums is the carry/borrow out of bit W/2-1.
  always_comb begin
    add_full = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    sub_full = (W+1)'(a) - (W+1)'(b) - (W+1)'(cin);
    add_half = (HW+1)'(a[HW-1:0]) + (HW+1)'(b[HW-1:0]) + (HW+1)'(cin);
    sub_half = (HW+1)'(a[HW-1:0]) - (HW+1)'(b[HW-1:0]) - (HW+1)'(cin);
    bit_sel  = W'(1) << idx;
  end

  always_comb begin
    res  = a;
    cout = 1'b0;
    hout = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        res = add_full[W-1:0]; cout = add_full[W]; hout = add_half[HW];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        res = sub_full[W-1:0]; cout = sub_full[W]; hout = sub_half[HW];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_RLC:  begin res = {a[W-2:0], a[W-1]}; cout = a[W-1]; end
      OP_RRC:  begin res = {a[0], a[W-1:1]};   cout = a[0];   end
      OP_RL:   begin res = {a[W-2:0], cin};    cout = a[W-1]; end
      OP_RR:   begin res = {cin, a[W-1:1]};    cout = a[0];   end
      OP_SLA:  begin res = {a[W-2:0], 1'b0};   cout = a[W-1]; end
      OP_SRA:  begin res = {a[W-1], a[W-1:1]}; cout = a[0];   end
      OP_SRL:  begin res = {1'b0, a[W-1:1]};   cout = a[0];   end
      OP_SWAP: res = {a[HW-1:0], a[W-1:HW]};
      // BIT leaves only the tested bit so the caller's zero test gives Z.
      OP_BIT:  res = a & bit_sel;
      OP_SET:  res = a | bit_sel;
      OP_RES:  res = a & ~bit_sel;
      OP_CPL:  res = ~a;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with Z/N/H/C flag register; narrow ops in one cycle,
// ADDW as two W-bit passes through the shared alu_pass.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = $clog2(W)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [IW-1:0]   req_idx,
  input  logic [2*W-1:0]  req_a,
  input  logic [2*W-1:0]  req_b,
  output logic [2*W-1:0]  res,
  output logic            res_valid,
  output logic            res_we,
  output logic            op_illegal,
  output logic [3:0]      flags_q,
  input  logic            flags_load,
  input  logic [3:0]      flags_in,
  output logic            busy
);

  typedef enum logic {IDLE, WIDE_HI} state_e;

  state_e       state;
  logic [W-1:0] a_hi_q, b_hi_q, lo_q;
  logic         carry_q;

  op_e          op;
  logic         illegal, wide, we_n;
  logic [W-1:0] a_lo, pass_a, pass_b, pass_res, res_w;
  logic [W-1:0] daa_corr, daa_res;
  logic         daa_c, pass_cin, pass_cout, pass_hout;
  op_e          pass_op;
  logic [3:0]   nf, mask;

  assign req_ready = (state == IDLE) & ~flags_load;
  assign busy      = (state != IDLE);

  always_comb begin
    op      = op_e'(req_op);
    wide    = (state == WIDE_HI);
    a_lo    = req_a[W-1:0];
    illegal = (req_op > OP_LAST) || ((op == OP_DAA) && (W != 8));
    mask    = illegal ? 4'b0000 : flag_mask(op);
    we_n    = !illegal && !(op inside {OP_CP, OP_BIT, OP_SCF, OP_CCF});
  end

  // Pass input mux: high ADDW pass in WIDE_HI, otherwise the request.
  always_comb begin
    pass_a   = wide ? a_hi_q : a_lo;
    pass_b   = wide ? b_hi_q : req_b[W-1:0];
    pass_op  = (wide || op == OP_ADDW) ? OP_ADD : op;
    pass_cin = 1'b0;
    if (wide)
      pass_cin = carry_q;
    else if (op inside {OP_ADC, OP_SBC, OP_RL, OP_RR})
      pass_cin = flags_q[FLAG_C];
  end

  alu_pass #(.W(W), .IW(IW)) u_pass (
    .a    (pass_a),
    .b    (pass_b),
    .cin  (pass_cin),
    .op   (pass_op),
    .idx  (req_idx),
    .res  (pass_res),
    .cout (pass_cout),
    .hout (pass_hout)
  );

  // Decimal adjust after BCD add/subtract; only reachable when W == 8.
  always_comb begin
    daa_corr = '0;
    daa_c    = flags_q[FLAG_C];
    if (!flags_q[FLAG_N]) begin
      if (flags_q[FLAG_C] || a_lo > W'(DAA_HI_LIMIT)) begin
        daa_corr = daa_corr | W'(DAA_HI_CORR);
        daa_c    = 1'b1;
      end
      if (flags_q[FLAG_H] || a_lo[3:0] > DAA_LO_LIMIT)
        daa_corr = daa_corr | W'(DAA_LO_CORR);
      daa_res = a_lo + daa_corr;
    end else begin
      if (flags_q[FLAG_C]) daa_corr = daa_corr | W'(DAA_HI_CORR);
      if (flags_q[FLAG_H]) daa_corr = daa_corr | W'(DAA_LO_CORR);
      daa_res = a_lo - daa_corr;
    end
  end

  always_comb begin
    if (illegal)            res_w = a_lo;
    else if (op == OP_DAA)  res_w = daa_res;
    else                    res_w = pass_res;
  end

  // Candidate flag values; mask decides which of them are written.
  always_comb begin
    nf         = flags_q;
    nf[FLAG_Z] = (res_w == '0);
    nf[FLAG_N] = 1'b0;
    nf[FLAG_H] = 1'b0;
    nf[FLAG_C] = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin nf[FLAG_H] = pass_hout; nf[FLAG_C] = pass_cout; end
      OP_SUB, OP_SBC, OP_CP: begin
        nf[FLAG_N] = 1'b1; nf[FLAG_H] = pass_hout; nf[FLAG_C] = pass_cout;
      end
      OP_AND, OP_BIT: nf[FLAG_H] = 1'b1;
      OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL:
        nf[FLAG_C] = pass_cout;
      OP_DAA: nf[FLAG_C] = daa_c;
      OP_CPL: begin nf[FLAG_N] = 1'b1; nf[FLAG_H] = 1'b1; end
      OP_SCF: nf[FLAG_C] = 1'b1;
      OP_CCF: nf[FLAG_C] = ~flags_q[FLAG_C];
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      flags_q    <= '0;
      res        <= '0;
      res_valid  <= 1'b0;
      res_we     <= 1'b0;
      op_illegal <= 1'b0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
      lo_q       <= '0;
      carry_q    <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flags_load) begin
            flags_q <= flags_in;
          end else if (req_valid) begin
            if (!illegal && op == OP_ADDW) begin
              lo_q    <= pass_res;
              carry_q <= pass_cout;
              a_hi_q  <= req_a[2*W-1:W];
              b_hi_q  <= req_b[2*W-1:W];
              state   <= WIDE_HI;
            end else begin
              res        <= (2*W)'(res_w);
              res_we     <= we_n;
              op_illegal <= illegal;
              res_valid  <= 1'b1;
              flags_q    <= (flags_q & ~mask) | (nf & mask);
            end
          end
        end
        WIDE_HI: begin
          res             <= {pass_res, lo_q};
          res_we          <= 1'b1;
          op_illegal      <= 1'b0;
          res_valid       <= 1'b1;
          flags_q[FLAG_N] <= 1'b0;
          flags_q[FLAG_H] <= pass_hout;
          flags_q[FLAG_C] <= pass_cout;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: W=8 instance for the main flows, W=16 for DAA legality.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        v8, v16, flags_load, ld16;
  logic [4:0]  req_op;
  logic [3:0]  req_idx;
  logic [31:0] req_a, req_b;
  logic [3:0]  flags_in;

  logic        rdy8, rv8, we8, il8, busy8;
  logic [15:0] res8;
  logic [3:0]  fl8;
  logic        rdy16, rv16, we16, il16, busy16;
  logic [31:0] res16;
  logic [3:0]  fl16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  seq_alu #(.W(8)) u_dut (
    .CLK(CLK), .RESET(RESET), .req_valid(v8), .req_ready(rdy8),
    .req_op(req_op), .req_idx(req_idx[2:0]), .req_a(req_a[15:0]), .req_b(req_b[15:0]),
    .res(res8), .res_valid(rv8), .res_we(we8), .op_illegal(il8), .flags_q(fl8),
    .flags_load(flags_load), .flags_in(flags_in), .busy(busy8)
  );

  seq_alu #(.W(16)) u_dut16 (
    .CLK(CLK), .RESET(RESET), .req_valid(v16), .req_ready(rdy16),
    .req_op(req_op), .req_idx(req_idx), .req_a(req_a), .req_b(req_b),
    .res(res16), .res_valid(rv16), .res_we(we16), .op_illegal(il16), .flags_q(fl16),
    .flags_load(ld16), .flags_in(flags_in), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request for one accept edge; returns #1 after that edge.
  task automatic issue(input bit to16, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] idx);
    @(negedge CLK);
    req_op = op; req_a = a; req_b = b; req_idx = idx;
    if (to16) v16 = 1'b1; else v8 = 1'b1;
    @(posedge CLK);
    #1;
    v8 = 1'b0; v16 = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; v8 = 1'b0; v16 = 1'b0; flags_load = 1'b0; ld16 = 1'b0;
    req_op = '0; req_idx = '0; req_a = '0; req_b = '0; flags_in = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    check("rst_flags", 32'(fl8), 32'h0);
    check("rst_res", 32'(res8), 32'h0);
    check("rst_valid", 32'(rv8), 32'h0);
    check("rst_we", 32'(we8), 32'h0);
    check("rst_illegal", 32'(il8), 32'h0);
    check("rst_ready", 32'(rdy8), 32'h1);
    check("rst_busy", 32'(busy8), 32'h0);

    issue(0, OP_ADD, 32'h3A, 32'hC6, 4'd0);
    check("add_res", 32'(res8), 32'h00);
    check("add_flags", 32'(fl8), 32'hB);
    check("add_valid", 32'(rv8), 32'h1);
    check("add_we", 32'(we8), 32'h1);
    @(posedge CLK); #1;
    check("add_valid_pulse", 32'(rv8), 32'h0);

    issue(0, OP_ADD, 32'hFF, 32'h01, 4'd0);
    check("addff_res", 32'(res8), 32'h00);
    check("addff_c", 32'(fl8[FLAG_C]), 32'h1);
    check("b2b_ready", 32'(rdy8), 32'h1);
    issue(0, OP_ADC, 32'h00, 32'h00, 4'd0);
    check("adc_res", 32'(res8), 32'h01);
    check("adc_flags", 32'(fl8), 32'h0);
    check("adc_valid", 32'(rv8), 32'h1);

    // Flag load defers a pending ADDW by one cycle.
    @(negedge CLK);
    req_op = OP_ADDW; req_a = 32'h0FFF; req_b = 32'h0001; v8 = 1'b1;
    flags_load = 1'b1; flags_in = 4'hA;
    #1 check("ld_ready", 32'(rdy8), 32'h0);
    @(posedge CLK); #1;
    check("ld_flags", 32'(fl8), 32'hA);
    check("ld_not_taken", 32'(busy8), 32'h0);
    @(negedge CLK) flags_load = 1'b0;
    #1 check("ld_ready_after", 32'(rdy8), 32'h1);
    @(posedge CLK); #1 v8 = 1'b0;
    check("addw_busy", 32'(busy8), 32'h1);
    check("addw_ready_low", 32'(rdy8), 32'h0);
    check("addw_no_early_valid", 32'(rv8), 32'h0);
    @(posedge CLK); #1;
    check("addw_valid", 32'(rv8), 32'h1);
    check("addw_res", 32'(res8), 32'h1000);
    check("addw_flags", 32'(fl8), 32'hA);
    check("addw_we", 32'(we8), 32'h1);
    check("addw_idle", 32'(busy8), 32'h0);

    issue(0, OP_ADD, 32'h45, 32'h38, 4'd0);
    check("bcd_add_res", 32'(res8), 32'h7D);
    check("bcd_add_flags", 32'(fl8), 32'h0);
    issue(0, OP_DAA, 32'h7D, 32'h00, 4'd0);
    check("daa_res", 32'(res8), 32'h83);
    check("daa_flags", 32'(fl8), 32'h0);
    check("daa_legal", 32'(il8), 32'h0);

    issue(0, OP_SCF, 32'h00, 32'h00, 4'd0);
    check("scf_flags", 32'(fl8), 32'h1);
    check("scf_we", 32'(we8), 32'h0);
    issue(0, OP_BIT, 32'h7F, 32'h00, 4'd7);
    check("bit_flags", 32'(fl8), 32'hB);
    check("bit_we", 32'(we8), 32'h0);
    issue(0, OP_SET, 32'h00, 32'h00, 4'd0);
    check("set_res", 32'(res8), 32'h01);
    check("set_flags", 32'(fl8), 32'hB);
    issue(0, OP_RLC, 32'h80, 32'h00, 4'd0);
    check("rlc_res", 32'(res8), 32'h01);
    check("rlc_flags", 32'(fl8), 32'h1);

    issue(0, OP_SUB, 32'h10, 32'h01, 4'd0);
    check("sub_res", 32'(res8), 32'h0F);
    check("sub_flags", 32'(fl8), 32'h6);
    issue(0, OP_CP, 32'h05, 32'h05, 4'd0);
    check("cp_flags", 32'(fl8), 32'hC);
    check("cp_we", 32'(we8), 32'h0);
    issue(0, 5'd30, 32'h55, 32'h00, 4'd0);
    check("ill_flag", 32'(il8), 32'h1);
    check("ill_res", 32'(res8), 32'h55);
    check("ill_we", 32'(we8), 32'h0);
    check("ill_flags", 32'(fl8), 32'hC);
    issue(0, OP_CCF, 32'h00, 32'h00, 4'd0);
    check("ccf_flags", 32'(fl8), 32'h9);
    issue(0, OP_SWAP, 32'hA5, 32'h00, 4'd0);
    check("swap_res", 32'(res8), 32'h5A);
    check("swap_flags", 32'(fl8), 32'h0);
    issue(0, OP_SCF, 32'h00, 32'h00, 4'd0);
    check("scf2_flags", 32'(fl8), 32'h1);

    issue(1, OP_ADD, 32'h00FF, 32'h0001, 4'd0);
    check("w16_add_res", res16, 32'h0100);
    check("w16_add_flags", 32'(fl16), 32'h2);
    issue(1, OP_DAA, 32'h1234, 32'h0000, 4'd0);
    check("w16_daa_illegal", 32'(il16), 32'h1);
    check("w16_daa_res", res16, 32'h1234);
    check("w16_daa_flags", 32'(fl16), 32'h2);
    check("w16_daa_we", 32'(we16), 32'h0);
    check("w16_daa_valid", 32'(rv16), 32'h1);

    // Reset while the high ADDW pass is pending.
    issue(0, OP_ADDW, 32'h00FF, 32'h0001, 4'd0);
    check("rst_wide_busy", 32'(busy8), 32'h1);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    check("rstw_flags", 32'(fl8), 32'h0);
    check("rstw_valid", 32'(rv8), 32'h0);
    check("rstw_ready", 32'(rdy8), 32'h1);
    @(posedge CLK); #1;
    check("rstw_no_pulse", 32'(rv8), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
